// File: rtl/vx_credit_arb_pkg.sv
// Shared widths, helper functions and types for the credit arbiter and its round-robin picker.
package vx_credit_arb_pkg;

  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int sizew(input int maxPending);
    return $clog2(maxPending + 1);
  endfunction

  localparam int DFLT_NUM_REQS    = 4;
  localparam int DFLT_MAX_PENDING = 16;
  localparam int DFLT_REQ_IDXW    = log2up(DFLT_NUM_REQS);
  localparam int DFLT_SIZEW       = sizew(DFLT_MAX_PENDING);

  // Types for the default configuration; parameterised instances size their own signals.
  typedef logic [DFLT_REQ_IDXW-1:0] req_idx_t;
  typedef logic [DFLT_SIZEW-1:0]    credit_cnt_t;

endpackage

// File: rtl/vx_rr_picker.sv
// Combinational round-robin select: first eligible index at or after ptr_i, wrapping modulo N.
module vx_rr_picker
  import vx_credit_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDXW = log2up(N)
) (
  input  logic [N-1:0]    eligible_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [IDXW-1:0] idx_o,
  output logic            valid_o
);

  logic found;

  // First pass covers ptr..N-1, second pass wraps around to 0..ptr-1.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && eligible_i[i] && (IDXW'(i) >= ptr_i)) begin
        found      = 1'b1;
        grant_o[i] = 1'b1;
        idx_o      = IDXW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && eligible_i[i]) begin
        found      = 1'b1;
        grant_o[i] = 1'b1;
        idx_o      = IDXW'(i);
      end
    end
  end

  assign valid_o = found;

endmodule

// File: rtl/vx_credit_arbiter.sv
// Credit-gated round-robin arbiter feeding a one-entry registered output stage.
// Optional per-requester outstanding caps are enabled by defining VX_CREDIT_ARB_REQ_LIMIT_EN.
module vx_credit_arbiter
  import vx_credit_arb_pkg::*;
#(
  parameter int NUM_REQS    = 4,
  parameter int MAX_PENDING = 16,
  parameter int REQ_LIMIT   = 8,
  parameter int DATAW       = 32,
  parameter int REQ_IDXW    = log2up(NUM_REQS),
  parameter int SIZEW       = sizew(MAX_PENDING)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      out_valid,
  output logic [DATAW-1:0]          out_data,
  output logic [REQ_IDXW-1:0]       out_idx,
  input  logic                      out_ready,
  input  logic                      rsp_valid,
  input  logic [REQ_IDXW-1:0]       rsp_idx,
  output logic [SIZEW-1:0]          pending,
  output logic                      empty,
  output logic                      full
);

  logic                out_valid_q, out_valid_d;
  logic [DATAW-1:0]    out_data_q;
  logic [REQ_IDXW-1:0] out_idx_q;
  logic [REQ_IDXW-1:0] ptr_q, ptr_d;
  logic [SIZEW-1:0]    pending_q, pending_d;
  logic                empty_q, full_q;

  logic                can_load, credit_ok;
  logic [NUM_REQS-1:0] limit_block, eligible, grant;
  logic [REQ_IDXW-1:0] grant_idx;
  logic                grant_any;
  logic [DATAW-1:0]    sel_data;

  // Only the registered count gates issue, so a completion frees its credit a cycle later.
  assign can_load  = !out_valid_q || out_ready;
  assign credit_ok = pending_q < SIZEW'(MAX_PENDING);
  assign eligible  = req_valid & ~limit_block & {NUM_REQS{can_load && credit_ok}};

  vx_rr_picker #(
    .N    (NUM_REQS),
    .IDXW (REQ_IDXW)
  ) u_picker (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .idx_o      (grant_idx),
    .valid_o    (grant_any)
  );

  assign req_ready = grant;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant[i]) sel_data = req_data[i*DATAW +: DATAW];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    pending_d   = pending_q;
    if (grant_any) begin
      out_valid_d = 1'b1;
      ptr_d       = (grant_idx == REQ_IDXW'(NUM_REQS - 1)) ? '0 : grant_idx + REQ_IDXW'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // Issue and completion together cancel; a stray completion at zero saturates.
    if (grant_any && !rsp_valid) begin
      pending_d = pending_q + SIZEW'(1);
    end else if (!grant_any && rsp_valid && (pending_q != '0)) begin
      pending_d = pending_q - SIZEW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
      pending_q   <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
      pending_q   <= pending_d;
      empty_q     <= (pending_d == '0);
      full_q      <= (pending_d == SIZEW'(MAX_PENDING));
    end
  end

  always_ff @(posedge clk) begin
    if (grant_any) begin
      out_data_q <= sel_data;
      out_idx_q  <= grant_idx;
    end
  end

  assert property (@(posedge clk) disable iff (reset) !(rsp_valid && (pending_q == '0)));

`ifdef VX_CREDIT_ARB_REQ_LIMIT_EN
  localparam int CNTW = $clog2(REQ_LIMIT + 1);

  logic [CNTW-1:0] req_cnt_q [NUM_REQS];

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_req_cnt
    logic inc, dec;
    assign inc            = grant[g];
    assign dec            = rsp_valid && (rsp_idx == REQ_IDXW'(g));
    assign limit_block[g] = (req_cnt_q[g] == CNTW'(REQ_LIMIT));

    always_ff @(posedge clk) begin
      if (reset) begin
        req_cnt_q[g] <= '0;
      end else if (inc && !dec) begin
        req_cnt_q[g] <= req_cnt_q[g] + CNTW'(1);
      end else if (!inc && dec && (req_cnt_q[g] != '0)) begin
        req_cnt_q[g] <= req_cnt_q[g] - CNTW'(1);
      end
    end

    assert property (@(posedge clk) disable iff (reset) !(dec && (req_cnt_q[g] == '0)));
  end
`else
  logic rsp_idx_unused;
  assign rsp_idx_unused = ^rsp_idx;
  assign limit_block    = '0;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign pending   = pending_q;
  assign empty     = empty_q;
  assign full      = full_q;

endmodule

// File: tb/tb_vx_credit_arbiter.sv
// Directed table-driven bench for vx_credit_arbiter (4 requesters, 4 credits, per-requester cap 2).
module tb_vx_credit_arbiter;

  localparam int NUM_REQS    = 4;
  localparam int MAX_PENDING = 4;
  localparam int REQ_LIMIT   = 2;
  localparam int DATAW       = 32;
  localparam int REQ_IDXW    = 2;
  localparam int SIZEW       = 3;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQS-1:0]       req_valid;
  logic [NUM_REQS*DATAW-1:0] req_data;
  logic [NUM_REQS-1:0]       req_ready;
  logic                      out_valid;
  logic [DATAW-1:0]          out_data;
  logic [REQ_IDXW-1:0]       out_idx;
  logic                      out_ready;
  logic                      rsp_valid;
  logic [REQ_IDXW-1:0]       rsp_idx;
  logic [SIZEW-1:0]          pending;
  logic                      empty;
  logic                      full;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic [3:0] rv;
    logic       oReady;
    logic       rsp;
    logic [1:0] rspIdx;
    logic [3:0] expReady;
    logic       expValid;
    logic [1:0] expIdx;
    logic [2:0] expPending;
    logic       expEmpty;
    logic       expFull;
  } vec_t;

  vx_credit_arbiter #(
    .NUM_REQS    (NUM_REQS),
    .MAX_PENDING (MAX_PENDING),
    .REQ_LIMIT   (REQ_LIMIT),
    .DATAW       (DATAW),
    .REQ_IDXW    (REQ_IDXW),
    .SIZEW       (SIZEW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_ready (out_ready),
    .rsp_valid (rsp_valid),
    .rsp_idx   (rsp_idx),
    .pending   (pending),
    .empty     (empty),
    .full      (full)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dataOf(input logic [1:0] idx);
    return 32'hC0DE_0000 + {30'd0, idx};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    check({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, v.expValid});
    if (v.expValid) begin
      check({tag, " out_idx"}, {30'd0, out_idx}, {30'd0, v.expIdx});
      check({tag, " out_data"}, out_data, dataOf(v.expIdx));
    end
    check({tag, " pending"}, {29'd0, pending}, {29'd0, v.expPending});
    check({tag, " empty"}, {31'd0, empty}, {31'd0, v.expEmpty});
    check({tag, " full"}, {31'd0, full}, {31'd0, v.expFull});
  endtask

  // Drive mid-cycle, check the combinational grant, then check registered state after the edge.
  task automatic applyStimulus(input string tag, input vec_t v);
    @(negedge clk);
    req_valid = v.rv;
    out_ready = v.oReady;
    rsp_valid = v.rsp;
    rsp_idx   = v.rspIdx;
    #1;
    check({tag, " req_ready"}, {28'd0, req_ready}, {28'd0, v.expReady});
    @(posedge clk);
    #1;
    checkOutput(tag, v);
  endtask

  vec_t vecs[$];

  initial begin
    for (int i = 0; i < NUM_REQS; i++) req_data[i*DATAW +: DATAW] = dataOf(2'(i));
    reset     = 1'b1;
    req_valid = '0;
    out_ready = 1'b1;
    rsp_valid = 1'b0;
    rsp_idx   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset pending", {29'd0, pending}, 32'd0);
    check("reset empty", {31'd0, empty}, 32'd1);
    check("reset full", {31'd0, full}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

`ifdef VX_CREDIT_ARB_REQ_LIMIT_EN
    // Requester 0 hogs until its cap of 2; a completion for it reopens it a cycle later.
    vecs.push_back('{4'b0001, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 3'd1, 1'b0, 1'b0});
    vecs.push_back('{4'b0001, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 3'd2, 1'b0, 1'b0});
    vecs.push_back('{4'b0011, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 3'd3, 1'b0, 1'b0});
    vecs.push_back('{4'b0011, 1'b1, 1'b1, 2'd0, 4'b0010, 1'b1, 2'd1, 3'd3, 1'b0, 1'b0});
    vecs.push_back('{4'b0001, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 3'd4, 1'b0, 1'b1});
`else
    // Single requester fills all credits, then the fifth request is held off.
    vecs.push_back('{4'b0001, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 3'd1, 1'b0, 1'b0});
    vecs.push_back('{4'b0001, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 3'd2, 1'b0, 1'b0});
    vecs.push_back('{4'b0001, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 3'd3, 1'b0, 1'b0});
    vecs.push_back('{4'b0001, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 3'd4, 1'b0, 1'b1});
    vecs.push_back('{4'b0001, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 3'd4, 1'b0, 1'b1});
    // Full plus completion: grant only on the following cycle, count back at MAX after that.
    vecs.push_back('{4'b0001, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 2'd0, 3'd3, 1'b0, 1'b0});
    vecs.push_back('{4'b0001, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 3'd4, 1'b0, 1'b1});
    vecs.push_back('{4'b0000, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 2'd0, 3'd3, 1'b0, 1'b0});
    vecs.push_back('{4'b0000, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 2'd0, 3'd2, 1'b0, 1'b0});
    vecs.push_back('{4'b0000, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 2'd0, 3'd1, 1'b0, 1'b0});
    vecs.push_back('{4'b0000, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0});
    // All requesters valid with a completion each cycle: rotation from ptr=1, count steady.
    vecs.push_back('{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 3'd1, 1'b0, 1'b0});
    vecs.push_back('{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0100, 1'b1, 2'd2, 3'd1, 1'b0, 1'b0});
    vecs.push_back('{4'b1111, 1'b1, 1'b1, 2'd0, 4'b1000, 1'b1, 2'd3, 3'd1, 1'b0, 1'b0});
    vecs.push_back('{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 2'd0, 3'd1, 1'b0, 1'b0});
    vecs.push_back('{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0010, 1'b1, 2'd1, 3'd1, 1'b0, 1'b0});
    // Backpressure for three cycles holds the stage, then flow resumes.
    vecs.push_back('{4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd1, 3'd1, 1'b0, 1'b0});
    vecs.push_back('{4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd1, 3'd1, 1'b0, 1'b0});
    vecs.push_back('{4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd1, 3'd1, 1'b0, 1'b0});
    vecs.push_back('{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd2, 3'd2, 1'b0, 1'b0});
    vecs.push_back('{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 3'd2, 1'b0, 1'b0});
    vecs.push_back('{4'b0010, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 3'd3, 1'b0, 1'b0});
`endif

    foreach (vecs[i]) applyStimulus($sformatf("vec%0d", i), vecs[i]);

    // Mid-operation reset drops the held output and all credits, and ptr restarts at 0.
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    rsp_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("midreset out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset pending", {29'd0, pending}, 32'd0);
    check("midreset empty", {31'd0, empty}, 32'd1);
    check("midreset full", {31'd0, full}, 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("postreset req_ready", {28'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("postreset out_idx", {30'd0, out_idx}, 32'd0);
    check("postreset pending", {29'd0, pending}, 32'd1);
    @(negedge clk);
    req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
